// File: rtl/conv_sched_pkg.sv
// Shared definitions for the 3x3 convolution window scheduler:
// FSM state encoding, pipeline/window geometry and filter mode codes.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Cycles from window update to a valid convolver result.
  localparam int PIPE_DEPTH = 2;
  // Window is WIN_SIZE x WIN_SIZE pixels.
  localparam int WIN_SIZE = 3;

  localparam logic MODE_LAPLACIAN = 1'b1;
  localparam logic MODE_GRADIENT  = 1'b0;

endpackage

// File: rtl/conv_window_scheduler_line_buffer.sv
// conv_line_buffer: one image row of pixels, single port, asynchronous read
// and synchronous write. A read and a write to the same address in one cycle
// returns the old contents (read-before-write). Contents are not reset.
module conv_line_buffer
  import conv_sched_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Store the new pixel for this column; the old value is already on rdata.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: streams a raster image through two line buffers and
// a 3x3 window register feeding an external convolver, then tags the
// convolver's registered result with its centre coordinate.
// Optional feature: define CONV_SCHED_STALL_CNT_EN to add the stall_cycles
// output counting RUN cycles with no input pixel offered.
//
// Input handshake: a pixel transfers on a rising edge where in_valid and
// in_ready are both high; in_ready depends only on the FSM state, never on
// in_valid. The output side has no ready: the sink always accepts.
module conv_window_scheduler
  import conv_sched_pkg::*;
#(
  parameter int BIT_PER_PIXEL = 8,
  parameter int IMG_WIDTH     = 64,
  parameter int IMG_HEIGHT    = 48,
  parameter int COORD_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode_req,
  input  logic                     in_valid,
  input  logic [BIT_PER_PIXEL-1:0] in_pixel,
  output logic                     in_ready,
  output logic                     conv_mode,
  output logic [BIT_PER_PIXEL-1:0] pixel_0,
  output logic [BIT_PER_PIXEL-1:0] pixel_1,
  output logic [BIT_PER_PIXEL-1:0] pixel_2,
  output logic [BIT_PER_PIXEL-1:0] pixel_3,
  output logic [BIT_PER_PIXEL-1:0] pixel_4,
  output logic [BIT_PER_PIXEL-1:0] pixel_5,
  output logic [BIT_PER_PIXEL-1:0] pixel_6,
  output logic [BIT_PER_PIXEL-1:0] pixel_7,
  output logic [BIT_PER_PIXEL-1:0] pixel_8,
  input  logic [7:0]               conv_result,
  output logic                     out_valid,
  output logic [7:0]               out_pixel,
  output logic [COORD_W-1:0]       out_row,
  output logic [COORD_W-1:0]       out_col,
  output logic                     busy,
  output logic                     frame_done
`ifdef CONV_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cycles
`endif
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] DONE  = ST_DONE;

  localparam int                 LB_AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int                 WIN_PIX   = WIN_SIZE * WIN_SIZE;
  localparam logic [COORD_W-1:0] COL_LAST  = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] ROW_LAST  = COORD_W'(IMG_HEIGHT - 1);
  localparam logic [COORD_W-1:0] EDGE      = COORD_W'(WIN_SIZE - 1);
  localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);
  localparam logic [1:0]         DRAIN_END = 2'(PIPE_DEPTH - 1);

  logic [1:0]               state;
  logic [1:0]               drain_cnt;
  logic [COORD_W-1:0]       row;
  logic [COORD_W-1:0]       col;
  logic                     acc;
  logic                     win_ok;
  logic [BIT_PER_PIXEL-1:0] lb_top;
  logic [BIT_PER_PIXEL-1:0] lb_mid;
  logic [BIT_PER_PIXEL-1:0] win [WIN_PIX];
  logic                     v1;
  logic [COORD_W-1:0]       r1;
  logic [COORD_W-1:0]       c1;

  assign acc    = in_valid && (state == RUN);
  // Only full windows: two rows and two columns already seen at this accept.
  assign win_ok = acc && (row >= EDGE) && (col >= EDGE);

  assign in_ready   = (state == RUN);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign out_pixel  = conv_result;

  assign pixel_0 = win[0];
  assign pixel_1 = win[1];
  assign pixel_2 = win[2];
  assign pixel_3 = win[3];
  assign pixel_4 = win[4];
  assign pixel_5 = win[5];
  assign pixel_6 = win[6];
  assign pixel_7 = win[7];
  assign pixel_8 = win[8];

  // Row-2 buffer: takes over the row-1 value as the row-1 buffer is rewritten.
  conv_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (BIT_PER_PIXEL),
    .AW    (LB_AW)
  ) u_lb_top (
    .clk   (clk),
    .we    (acc),
    .addr  (col[LB_AW-1:0]),
    .wdata (lb_mid),
    .rdata (lb_top)
  );

  // Row-1 buffer: takes the incoming pixel.
  conv_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (BIT_PER_PIXEL),
    .AW    (LB_AW)
  ) u_lb_mid (
    .clk   (clk),
    .we    (acc),
    .addr  (col[LB_AW-1:0]),
    .wdata (in_pixel),
    .rdata (lb_mid)
  );

  // Frame FSM with raster row/col counters and the latched filter mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 2'd0;
      row       <= '0;
      col       <= '0;
      conv_mode <= MODE_GRADIENT;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            conv_mode <= mode_req;
            row       <= '0;
            col       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (acc) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                drain_cnt <= 2'd0;
                state     <= DRAIN;
              end else begin
                row <= row + ONE;
              end
            end else begin
              col <= col + ONE;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_END) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Window shifts left on each accept; new right column is row-2, row-1, current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN_PIX; i++) begin
        win[i] <= '0;
      end
    end else if (acc) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int c = 0; c < WIN_SIZE - 1; c++) begin
          win[r*WIN_SIZE + c] <= win[r*WIN_SIZE + c + 1];
        end
      end
      win[WIN_SIZE-1]     <= lb_top;
      win[2*WIN_SIZE-1]   <= lb_mid;
      win[WIN_PIX-1]      <= in_pixel;
    end
  end

  // Valid/coordinate pipeline: stage 1 matches the window register, stage 2
  // matches the convolver's output register. Advances every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      r1        <= '0;
      c1        <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      v1 <= win_ok;
      if (win_ok) begin
        r1 <= row - ONE;
        c1 <= col - ONE;
      end
      out_valid <= v1;
      out_row   <= r1;
      out_col   <= c1;
    end
  end

`ifdef CONV_SCHED_STALL_CNT_EN
  // Saturating count of RUN cycles where the source offered nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if ((state == IDLE) && start) begin
      stall_cycles <= 16'd0;
    end else if ((state == RUN) && !in_valid && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: a 4x4 and a 4x3 instance, an external
// convolver model, and a frame-level reference that computes each expected
// result directly from the stored image.
module tb_conv_window_scheduler;
  import conv_sched_pkg::*;

  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b0;
  int   cyc    = 0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       start_a  = 1'b0;
  logic       start_b  = 1'b0;
  logic       mode_req = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_pixel = 8'd0;
  logic [7:0] a_cres   = 8'd0;
  logic [7:0] b_cres   = 8'd0;

  wire          a_in_ready, a_conv_mode, a_out_valid, a_busy, a_frame_done;
  wire [71:0]   a_win;
  wire [7:0]    a_out_pixel;
  wire [CW-1:0] a_out_row, a_out_col;
  wire          b_in_ready, b_conv_mode, b_out_valid, b_busy, b_frame_done;
  wire [71:0]   b_win;
  wire [7:0]    b_out_pixel;
  wire [CW-1:0] b_out_row, b_out_col;
`ifdef CONV_SCHED_STALL_CNT_EN
  wire [15:0]   a_stall, b_stall;
`endif

  conv_window_scheduler #(
    .BIT_PER_PIXEL(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .COORD_W(CW)
  ) u_a (
    .clk(clk), .rst(rst), .start(start_a), .mode_req(mode_req),
    .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(a_in_ready),
    .conv_mode(a_conv_mode),
    .pixel_0(a_win[7:0]),   .pixel_1(a_win[15:8]),  .pixel_2(a_win[23:16]),
    .pixel_3(a_win[31:24]), .pixel_4(a_win[39:32]), .pixel_5(a_win[47:40]),
    .pixel_6(a_win[55:48]), .pixel_7(a_win[63:56]), .pixel_8(a_win[71:64]),
    .conv_result(a_cres), .out_valid(a_out_valid), .out_pixel(a_out_pixel),
    .out_row(a_out_row), .out_col(a_out_col), .busy(a_busy),
    .frame_done(a_frame_done)
`ifdef CONV_SCHED_STALL_CNT_EN
    , .stall_cycles(a_stall)
`endif
  );

  conv_window_scheduler #(
    .BIT_PER_PIXEL(8), .IMG_WIDTH(4), .IMG_HEIGHT(3), .COORD_W(CW)
  ) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mode_req(mode_req),
    .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(b_in_ready),
    .conv_mode(b_conv_mode),
    .pixel_0(b_win[7:0]),   .pixel_1(b_win[15:8]),  .pixel_2(b_win[23:16]),
    .pixel_3(b_win[31:24]), .pixel_4(b_win[39:32]), .pixel_5(b_win[47:40]),
    .pixel_6(b_win[55:48]), .pixel_7(b_win[63:56]), .pixel_8(b_win[71:64]),
    .conv_result(b_cres), .out_valid(b_out_valid), .out_pixel(b_out_pixel),
    .out_row(b_out_row), .out_col(b_out_col), .busy(b_busy),
    .frame_done(b_frame_done)
`ifdef CONV_SCHED_STALL_CNT_EN
    , .stall_cycles(b_stall)
`endif
  );

  // Selected instance for the frame under test.
  bit sel = 1'b0;
  wire          m_in_ready   = sel ? b_in_ready   : a_in_ready;
  wire          m_conv_mode  = sel ? b_conv_mode  : a_conv_mode;
  wire          m_out_valid  = sel ? b_out_valid  : a_out_valid;
  wire [7:0]    m_out_pixel  = sel ? b_out_pixel  : a_out_pixel;
  wire [CW-1:0] m_out_row    = sel ? b_out_row    : a_out_row;
  wire [CW-1:0] m_out_col    = sel ? b_out_col    : a_out_col;
  wire          m_busy       = sel ? b_busy       : a_busy;
  wire          m_frame_done = sel ? b_frame_done : a_frame_done;

  // ---------------- convolver and reference ----------------
  // Laplacian: 8*centre minus the 8 neighbours. Gradient: top row sum minus
  // bottom row sum. Both clamp to 0..255.
  function automatic logic [7:0] conv_fn(input logic m, input logic [71:0] w);
    int s;
    s = 0;
    if (m == MODE_LAPLACIAN) begin
      s = 8 * int'(w[39:32]);
      for (int k = 0; k < 9; k++) if (k != 4) s = s - int'(w[k*8 +: 8]);
    end else begin
      s = int'(w[7:0]) + int'(w[15:8]) + int'(w[23:16])
        - int'(w[55:48]) - int'(w[63:56]) - int'(w[71:64]);
    end
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  always @(posedge clk) begin
    a_cres <= conv_fn(a_conv_mode, a_win);
    b_cres <= conv_fn(b_conv_mode, b_win);
  end

  logic [7:0] img [64];
  int         fw = 4;
  logic       frame_mode = 1'b0;

  function automatic logic [7:0] model_pix(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3 + j)*8 +: 8] = img[(r - 1 + i)*fw + (c - 1 + j)];
    return conv_fn(frame_mode, w);
  endfunction

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  logic [55:0] exp_q [$];   // {due cycle, row, col, pixel}
  logic [23:0] got_q [$];   // {row, col, pixel}
  int          exp_done_cyc = -1;
  int          done_seen = 0;
  bit          cmp_en = 1'b0;
  logic [55:0] cmp_e;
  int          cmp_due;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare of the selected instance against the reference queue.
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      if (m_out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          cmp_e   = exp_q.pop_front();
          cmp_due = int'(cmp_e[55:24]);
          check("out_cycle", cyc, cmp_due);
          check("out_row", int'(m_out_row), int'(cmp_e[23:16]));
          check("out_col", int'(m_out_col), int'(cmp_e[15:8]));
          check("out_pixel", int'(m_out_pixel), int'(cmp_e[7:0]));
          got_q.push_back({m_out_row, m_out_col, m_out_pixel});
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][55:24]) <= cyc) begin
        check("missing_out_valid", 0, 1);
        void'(exp_q.pop_front());
      end
      if (m_frame_done) done_seen++;
      if (m_frame_done || cyc == exp_done_cyc)
        check("frame_done_timing", int'(m_frame_done), (cyc == exp_done_cyc) ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_uniform(input logic [7:0] v);
    for (int i = 0; i < 64; i++) img[i] = v;
  endtask

  task automatic fill_hash();
    for (int i = 0; i < 64; i++) img[i] = 8'((i * 37 + 11) % 251);
  endtask

  task automatic abort_frame();
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_done_cyc = -1;
    in_valid = 1'b0;
    #1;
    check("abort_out_valid", int'(m_out_valid), 0);
    check("abort_frame_done", int'(m_frame_done), 0);
    check("abort_busy", int'(m_busy), 0);
    check("abort_in_ready", int'(m_in_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_seen, 0);
    check("abort_no_results", got_q.size(), 0);
    check("abort_idle", int'(m_busy), 0);
  endtask

  task automatic run_frame(input bit s, input int w, input int h, input logic mode,
                           input bit gap, input int stall_at, input int stall_n,
                           input int disturb_at, input int abort_at);
    int idx, guard, stall_left, last_cyc, r, c;
    bit tog, drive, disturbed;
    sel = s;
    fw = w;
    frame_mode = mode;
    exp_q.delete();
    got_q.delete();
    exp_done_cyc = -1;
    done_seen = 0;
    @(negedge clk);
    mode_req = mode;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check("busy_after_start", int'(m_busy), 1);
    check("ready_after_start", int'(m_in_ready), 1);
    check("conv_mode_latched", int'(m_conv_mode), int'(mode));
`ifdef CONV_SCHED_STALL_CNT_EN
    check("stall_clear_on_start", int'(s ? b_stall : a_stall), 0);
`endif
    idx = 0; guard = 0; stall_left = stall_n; last_cyc = 0;
    tog = 1'b0; disturbed = 1'b0;
    while (idx < w*h && guard < 1000) begin
      guard++;
      start_a = 1'b0;
      start_b = 1'b0;
      if (idx == abort_at) begin
        abort_frame();
        return;
      end
      if (disturbed) check("conv_mode_hold", int'(m_conv_mode), int'(mode));
      drive = 1'b1;
      if (gap) begin
        drive = !tog;
        tog = !tog;
      end
      if (idx == stall_at && stall_left > 0) begin
        drive = 1'b0;
        stall_left--;
      end
      if (idx == disturb_at && !disturbed) begin
        disturbed = 1'b1;
        mode_req = !mode;
        if (s) start_b = 1'b1; else start_a = 1'b1;
      end
      in_valid = drive;
      in_pixel = img[idx];
      if (drive) begin
        if (m_in_ready) begin
          r = idx / w;
          c = idx % w;
          if (r >= 2 && c >= 2)
            exp_q.push_back({32'(cyc + 2), 8'(r - 1), 8'(c - 1), model_pix(r - 1, c - 1)});
          if (idx == w*h - 1) begin
            exp_done_cyc = cyc + 3;
            last_cyc = cyc;
          end
          idx++;
        end else begin
          check("in_ready_in_run", int'(m_in_ready), 1);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    if (guard >= 1000) check("frame_guard", idx, w*h);
    while (cyc < last_cyc + 4) @(negedge clk);
    check("busy_low_after_frame", int'(m_busy), 0);
    check("ready_low_after_frame", int'(m_in_ready), 0);
    check("done_pulses", done_seen, 1);
    check("results_left", exp_q.size(), 0);
    check("result_count", got_q.size(), (w - 2)*(h - 2));
  endtask

  task automatic check_lits(input string name, input int n, input logic [95:0] lits);
    logic [23:0] g, l;
    check({name, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      g = got_q[i];
      l = lits[i*24 +: 24];
      check(name, int'(g), int'(l));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Asynchronous reset with the clock stopped.
    #3 rst = 1'b1;
    #1;
    check("rst_in_ready", int'(a_in_ready), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_out_valid", int'(a_out_valid), 0);
    check("rst_frame_done", int'(a_frame_done), 0);
    check("rst_conv_mode", int'(a_conv_mode), 0);
    check("rst_window", int'(a_win == 72'd0), 1);
    check("rst_out_row", int'(a_out_row), 0);
    check("rst_out_col", int'(a_out_col), 0);
    check("rst_b_out_valid", int'(b_out_valid), 0);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", int'(a_busy), 0);
    check("post_rst_in_ready", int'(a_in_ready), 0);
    cmp_en = 1'b1;

    // 4x4 Laplacian on a flat image: all results zero.
    fill_uniform(8'd10);
    run_frame(1'b0, 4, 4, MODE_LAPLACIAN, 1'b0, -1, 0, -1, -1);
    check_lits("lap_flat", 4, {24'h020200, 24'h020100, 24'h010200, 24'h010100});

    // 4x3 vertical gradient: bright top row saturates.
    for (int i = 0; i < 12; i++) img[i] = (i < 4) ? 8'd200 : 8'd0;
    run_frame(1'b1, 4, 3, MODE_GRADIENT, 1'b0, -1, 0, -1, -1);
    check_lits("grad_rows", 2, {48'd0, 24'h0102FF, 24'h0101FF});

    // Same flat 4x4 frame with in_valid toggling every cycle.
    fill_uniform(8'd10);
    run_frame(1'b0, 4, 4, MODE_LAPLACIAN, 1'b1, -1, 0, -1, -1);
    check_lits("lap_gappy", 4, {24'h020200, 24'h020100, 24'h010200, 24'h010100});

    // Irregular image, start pulse and mode flip mid-frame.
    fill_hash();
    run_frame(1'b0, 4, 4, MODE_LAPLACIAN, 1'b0, -1, 0, 6, -1);

    // Reset while a result is in flight.
    fill_hash();
    run_frame(1'b0, 4, 4, MODE_GRADIENT, 1'b0, -1, 0, -1, 11);

    // Clean frame after the aborted one.
    fill_hash();
    run_frame(1'b0, 4, 4, MODE_GRADIENT, 1'b0, -1, 0, -1, -1);

`ifdef CONV_SCHED_STALL_CNT_EN
    fill_uniform(8'd10);
    run_frame(1'b0, 4, 4, MODE_LAPLACIAN, 1'b0, 3, 5, -1, -1);
    check("stall_count", int'(a_stall), 5);
    run_frame(1'b0, 4, 4, MODE_LAPLACIAN, 1'b0, -1, 0, -1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
